mem_byte_copy_master: RTL and testbench
=======================================

// Module: mem_byte_copy_master
// PURPOSE
//  Bus-initiator (master) side of the single-channel minimal memory interface (Mout_*/M_* signals).
//  On a start_port pulse, copies LEN bytes from src to dst, one byte per read/write pair, ascending.
//  Sits between controller logic and the external memory responder.
//  Bambu-style start_port/done_port handshake; watchdog aborts a hung access.
// PARAMETERS
//  ADDR_W   7    byte address width; address arithmetic is modulo 2^ADDR_W
//  LEN_W    8    width of byte count
//  TIMEOUT  16   max cycles a strobe waits for M_DataRdy before abort (>=2)
// PORTS
//  clock               in   1       single clock, rising edge
//  reset               in   1       asynchronous, active-low
//  start_port          in   1       1-cycle pulse; samples src_addr/dst_addr/len
//  src_addr            in   ADDR_W  first source byte address
//  dst_addr            in   ADDR_W  first destination byte address
//  len                 in   LEN_W   byte count (0 allowed)
//  done_port           out  1       1-cycle pulse at end of job
//  err_port            out  1       1 = last job aborted by timeout
//  Mout_oe_ram         out  1       read strobe, held until M_DataRdy
//  Mout_we_ram         out  1       write strobe, held until M_DataRdy
//  Mout_addr_ram       out  ADDR_W  access address
//  Mout_Wdata_ram      out  8       write data
//  Mout_data_ram_size  out  4       access size in bits: 8 while a strobe is high, else 0
//  M_Rdata_ram         in   8       read data, valid in the M_DataRdy cycle
//  M_DataRdy           in   1       access-complete acknowledge
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; all outputs 0, including err_port; counters cleared.
//  FSM: IDLE, RD, WR, DONE.
//   IDLE: start_port=1 -> latch src, dst, and len into cnt; clear err_port.
//         If len==0, go to DONE; otherwise go to RD.
//   RD: oe=1, addr=src, size=8.
//       On M_DataRdy: capture M_Rdata_ram into a byte register; go to WR.
//   WR: we=1, addr=dst, Wdata=byte register, size=8.
//       On M_DataRdy: src+=1, dst+=1 (wrap mod 2^ADDR_W), cnt-=1.
//       Go to DONE if the new cnt==0; otherwise go to RD.
//   DONE: done_port=1 for exactly one cycle; then go to IDLE.
//  Strobe rules:
//   - oe and we are never high together.
//   - Strobe, addr, Wdata and size are registered outputs, stable while a strobe is high.
//   - WR->RD is back-to-back: no idle gap is required.
//   - Wdata=0 outside WR.
//  Latency: with responder read delay R and write delay W cycles,
//   done_port is high (R+W)*len+1 cycles after the start_port cycle.
//   Example: R=2, W=1 gives 3*len+1; len==0 gives done on cycle +1.
//  Watchdog: wait counter clears on every strobe entry and increments each RD/WR cycle without M_DataRdy.
//   If it reaches TIMEOUT-1 without M_DataRdy: drop the strobe next cycle, set err_port=1, go to DONE.
//   err_port holds until the next accepted start_port.
//  start_port outside IDLE is ignored, with no effect on the job in progress.
//  Overlapping ranges: copy is strictly ascending, byte by byte; dst>src overlap propagates bytes by design.
//  M_DataRdy while no strobe is high is ignored.
//  Reset mid-job: strobes drop asynchronously; the job is discarded; no done_port.
// TESTING
//  1. src=0x10, dst=0x40, len=4, responder R=2 W=1, mem[0x10..13]=A1 B2 C3 D4
//     -> mem[0x40..43]=A1 B2 C3 D4; done_port 13 cycles after start; err_port=0.
//  2. len=0 -> no strobe ever; done_port exactly 1 cycle after start.
//  3. src=0x7E, dst=0x00, len=3, ADDR_W=7 -> reads 7E,7F,00; writes 00,01,02; wrap is correct.
//  4. Responder never raises M_DataRdy on the first read, TIMEOUT=16
//     -> oe high 16 cycles then low; done_port pulses; err_port=1 until the next start.
//  5. start_port re-pulsed mid-job with different len -> ignored; original 4-byte copy completes unchanged.
//  6. reset low during WR of byte 2
//     -> all outputs 0 immediately; no done_port; a fresh start then copies correctly.
//  Every test: assertion that oe&we never both 1; assertion that addr/Wdata are stable while a strobe is high.

Source files
------------

// File: rtl/mem_byte_copy_master.sv
// mem_byte_copy_master: copies len bytes src->dst over the minimal memory bus, one read/write pair per byte.
module mem_byte_copy_master #(
  parameter int ADDR_W  = 7,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_port,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              done_port,
  output logic              err_port,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [7:0]        Mout_Wdata_ram,
  output logic [3:0]        Mout_data_ram_size,
  input  logic [7:0]        M_Rdata_ram,
  input  logic              M_DataRdy
);
  localparam int WW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d, wdata_q, wdata_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [3:0]        size_q, size_d;
  logic              err_q, err_d, done_q, done_d, oe_q, oe_d, we_q, we_d;
  logic              busy, tmo;
  assign busy = state_q == RD || state_q == WR;
  assign tmo  = busy && !M_DataRdy && wait_q == WW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    err_d   = err_q;
    wait_d  = busy && !M_DataRdy ? wait_q + WW'(1) : '0;
    case (state_q)
      IDLE: if (start_port) begin
        src_d   = src_addr;
        dst_d   = dst_addr;
        cnt_d   = len;
        err_d   = 1'b0;
        state_d = len == '0 ? DONE : RD;
      end
      RD: if (M_DataRdy) begin
        byte_d  = M_Rdata_ram;
        state_d = WR;
      end
      WR: if (M_DataRdy) begin
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = cnt_q == LEN_W'(1) ? DONE : RD;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = DONE;
      err_d   = 1'b1;
    end
    // Bus outputs are registered, so they are derived from the next state.
    oe_d    = state_d == RD;
    we_d    = state_d == WR;
    addr_d  = oe_d ? src_d : we_d ? dst_d : '0;
    wdata_d = we_d ? byte_d : '0;
    size_d  = oe_d || we_d ? 4'd8 : 4'd0;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      done_q  <= done_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
    end
  end
  assign done_port          = done_q;
  assign err_port           = err_q;
  assign Mout_oe_ram        = oe_q;
  assign Mout_we_ram        = we_q;
  assign Mout_addr_ram      = addr_q;
  assign Mout_Wdata_ram     = wdata_q;
  assign Mout_data_ram_size = size_q;
endmodule

// File: tb/tb_mem_byte_copy_master.sv
// tb_mem_byte_copy_master: responder model plus access scoreboard for mem_byte_copy_master.
module tb_mem_byte_copy_master;
  logic       clock = 1'b0, reset = 1'b0, start_port = 1'b0;
  logic [6:0] src_addr = '0, dst_addr = '0;
  logic [7:0] len = '0;
  logic       done_port, err_port, oe, we, rdy;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic [3:0] size;
  logic [7:0] mem [128];
  int         r_dly = 2, w_dly = 1, rcnt, oe_cnt;
  bit         hang = 0, pend = 0;
  logic [6:0] p_addr;
  logic [7:0] p_wdata;
  logic [1:0] p_str;
  int         vec_cnt = 0, err_cnt = 0;
  typedef struct {bit w; logic [6:0] a; logic [7:0] d;} acc_t;
  acc_t q[$];

  mem_byte_copy_master #(.ADDR_W(7), .LEN_W(8), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start_port(start_port),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .done_port(done_port), .err_port(err_port),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy)
  );

  always #5 clock = ~clock;

  assign rdy   = !hang && ((oe && rcnt == r_dly - 1) || (we && rcnt == w_dly - 1));
  assign rdata = oe ? mem[addr] : 8'h00;

  always_ff @(posedge clock or negedge reset)
    if (!reset) rcnt <= 0;
    else rcnt <= (oe || we) && !rdy ? rcnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      assert (!(oe && we));
      chk("oe_we_excl", {31'd0, oe && we}, 0);
      chk("size", {28'd0, size}, (oe || we) ? 8 : 0);
      if (!we) chk("wdata_idle", {24'd0, wdata}, 0);
      if (pend && (oe || we)) begin
        assert (addr == p_addr && wdata == p_wdata);
        chk("stab_addr", {25'd0, addr}, {25'd0, p_addr});
        chk("stab_wdata", {24'd0, wdata}, {24'd0, p_wdata});
        chk("stab_strobe", {30'd0, oe, we}, {30'd0, p_str});
      end
      if (oe) oe_cnt++;
      if ((oe || we) && rdy) begin
        if (q.size() == 0) chk("unexp_access", 1, 0);
        else begin
          acc_t e;
          e = q.pop_front();
          chk("acc_kind", {31'd0, we}, {31'd0, e.w});
          chk("acc_addr", {25'd0, addr}, {25'd0, e.a});
          if (we) chk("acc_data", {24'd0, wdata}, {24'd0, e.d});
        end
        if (we) mem[addr] = wdata;
      end
      pend    = (oe || we) && !rdy;
      p_addr  = addr;
      p_wdata = wdata;
      p_str   = {oe, we};
    end else pend = 0;
  end

  // Expected accesses follow a strictly ascending byte-by-byte copy on a shadow memory.
  task automatic launch(input logic [6:0] s, input logic [6:0] d, input logic [7:0] n);
    logic [7:0] m [128];
    m = mem;
    if (!hang)
      for (int i = 0; i < n; i++) begin
        logic [6:0] sa, da;
        sa = s + 7'(i);
        da = d + 7'(i);
        q.push_back('{1'b0, sa, m[sa]});
        m[da] = m[sa];
        q.push_back('{1'b1, da, m[da]});
      end
    @(negedge clock);
    src_addr = s; dst_addr = d; len = n; start_port = 1'b1; oe_cnt = 0;
    @(negedge clock);
    start_port = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input bit exp_err, input bit repulse);
    int lat;
    lat = 1;
    while (!done_port && lat < 500) begin
      start_port = repulse && lat == 5;
      if (start_port) begin src_addr = 7'h33; dst_addr = 7'h66; len = 8'd7; end
      @(negedge clock);
      lat++;
    end
    start_port = 1'b0;
    chk({tag, "_done_lat"}, lat, exp_lat);
    chk({tag, "_err"}, {31'd0, err_port}, {31'd0, exp_err});
    chk({tag, "_q_empty"}, q.size(), 0);
    @(negedge clock);
    chk({tag, "_done_pulse"}, {31'd0, done_port}, 0);
    chk({tag, "_err_hold"}, {31'd0, err_port}, {31'd0, exp_err});
  endtask

  initial begin
    logic [7:0] pat [4];
    int k;
    pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = pat[i];
    #1 chk("reset_outs", {9'd0, oe, we, addr, wdata, size, done_port, err_port}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    launch(7'h10, 7'h40, 8'd4);
    wait_done("t1", 13, 0, 0);
    for (int i = 0; i < 4; i++) chk("t1_mem", {24'd0, mem[7'h40 + i]}, {24'd0, pat[i]});

    launch(7'h20, 7'h30, 8'd0);
    wait_done("t2", 1, 0, 0);
    chk("t2_no_strobe", oe_cnt, 0);

    launch(7'h7E, 7'h00, 8'd3);
    wait_done("t3", 10, 0, 0);

    hang = 1;
    launch(7'h05, 7'h60, 8'd2);
    wait_done("t4", 17, 1, 0);
    chk("t4_oe_cycles", oe_cnt, 16);
    repeat (3) @(negedge clock);
    chk("t4_err_sticky", {31'd0, err_port}, 1);
    hang = 0;

    r_dly = 1; w_dly = 3;
    launch(7'h10, 7'h48, 8'd4);
    wait_done("t5", 17, 0, 1);
    r_dly = 2; w_dly = 1;

    launch(7'h20, 7'h50, 8'd4);
    k = 0;
    while (!(we && addr == 7'h51) && k < 100) begin @(negedge clock); k++; end
    chk("t6_reach_wr2", {31'd0, k < 100}, 1);
    #1 reset = 1'b0;
    #1 chk("t6_async_clear", {9'd0, oe, we, addr, wdata, size, done_port, err_port}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t6_no_done", {31'd0, done_port}, 0);
    end
    reset = 1'b1;
    q.delete();
    launch(7'h20, 7'h50, 8'd4);
    wait_done("t6b", 13, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
